alu_dec: RTL and testbench
==========================

ALU_DEC -- requirements
Module: alu_dec

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-002 Ports SHALL be as follows:
- Clock  input  1  rising-edge clock
- Reset_n  input  1  asynchronous, active-low reset
- opcode  input  7  RV32I opcode field
- funct  input  3  funct3 field
- add_rshift_type  input  1  instruction bit 30 (sub/sra select)
- A  input  32  operand A
- B  input  32  operand B (immediate or rs2)
- ALUop  output  4  decoded operation
- Out  output  32  combinational result
- Out_q  output  32  result, registered or pass-through per REQ-020
REQ-003 Opcode encodings SHALL be:
- LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111
- BRANCH 1100011, LOAD 0000011, STORE 0100011
- ARI_ITYPE 0010011, ARI_RTYPE 0110011, CSR 1110011, NOOP 0000000
REQ-004 ALUop encodings SHALL be: ADD 0, SUB 1, SLL 2, SLT 3, SLTU 4, XOR 5, SRL 6, SRA 7, OR 8, AND 9, COPY_B 10, COPY_A 11, ZERO 15; codes 12-14 unused.

Function
REQ-005 Decode and datapath SHALL be purely combinational from opcode/funct/add_rshift_type/A/B to ALUop and Out, with no X propagation on any defined opcode.
REQ-006 LUI SHALL decode to COPY_B for any funct/add_rshift_type.
REQ-007 AUIPC, JAL, BRANCH, LOAD and STORE SHALL decode to ADD for any funct/add_rshift_type.
REQ-008 JALR SHALL decode to ADD.
REQ-009 ARI_RTYPE SHALL decode funct as: 000 ADD (add_rshift_type=0) / SUB (=1); 001 SLL; 010 SLT; 011 SLTU; 100 XOR; 101 SRL (=0) / SRA (=1); 110 OR; 111 AND. add_rshift_type SHALL be ignored for all funct except 000 and 101.
REQ-010 ARI_ITYPE SHALL decode as ARI_RTYPE except that funct 000 is always ADD regardless of add_rshift_type.
REQ-011 CSR SHALL decode to COPY_A for any funct.
REQ-012 NOOP and every undefined opcode SHALL decode to ZERO, even with funct unknown.
REQ-013 ADD/SUB SHALL be 32-bit modulo (carry/borrow discarded).
REQ-014 SLL/SRL/SRA SHALL shift A by B[4:0]; B[31:5] SHALL be ignored; SRA SHALL replicate A[31].
REQ-015 SLT SHALL be a signed A<B compare and SLTU an unsigned compare; both SHALL output 32'd1 if true, else 32'd0.
REQ-016 XOR/OR/AND SHALL be bitwise; COPY_A SHALL output A; COPY_B SHALL output B; ZERO and unused codes SHALL output 32'd0.

Reset
REQ-017 Reset_n low SHALL immediately clear Out_q to 32'd0 when REQ-020 applies, independent of Clock.
REQ-018 Reset SHALL NOT affect the combinational ALUop/Out path.
REQ-019 The first rising Clock after Reset_n deasserts SHALL load the current Out into Out_q.

Configuration
REQ-020 With ALU_OUT_REG_EN defined, Out_q SHALL be a register loaded with Out on every rising Clock edge, i.e. 1-cycle latency.
REQ-021 Without ALU_OUT_REG_EN, Out_q SHALL equal Out combinationally, and Clock/Reset_n SHALL be unused.

Verification
REQ-022 ARI_RTYPE, funct 000, add_rshift_type 1, A=0x00000005, B=0x00000007 -> ALUop=1, Out=0xFFFFFFFE.
REQ-023 ARI_ITYPE, funct 101, add_rshift_type 1, A=0x80000000, B=0xFFFF8024 -> Out=0xF8000000 (shift by 4); same with add_rshift_type 0 -> Out=0x08000000.
REQ-024 ARI_RTYPE, funct 010, A=0xFFFFFFFF, B=0x00000001 -> Out=1; funct 011 with the same operands -> Out=0.
REQ-025 LUI, random funct, B=0x12345000 -> Out=0x12345000; CSR, funct 101, A=0xDEADBEEF -> Out=0xDEADBEEF; NOOP with funct=X -> Out=0.
REQ-026 ARI_ITYPE, funct 000, add_rshift_type 1, A=0xFFFFFFFF, B=0x00000001 -> ALUop=0, Out=0x00000000 (ADD, wrap-around).
REQ-027 With ALU_OUT_REG_EN: Out_q SHALL be 0 during reset; after release, Out_q SHALL equal the prior-cycle Out; asserting Reset_n low mid-stream SHALL clear Out_q without a clock edge.

Source files
------------

// File: rtl/alu_dec.sv
// RV32I ALU operation decoder plus combinational datapath.
// Define ALU_OUT_REG_EN to register the result on Out_q; otherwise Out_q mirrors Out.
module alu_dec (
    input  logic        Clock,
    input  logic        Reset_n,
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct,
    input  logic        add_rshift_type,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic [3:0]  ALUop,
    output logic [31:0] Out,
    output logic [31:0] Out_q
);

    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] OPC_JAL       = 7'b1101111;
    localparam logic [6:0] OPC_JALR      = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;
    localparam logic [6:0] OPC_ARI_ITYPE = 7'b0010011;
    localparam logic [6:0] OPC_ARI_RTYPE = 7'b0110011;
    localparam logic [6:0] OPC_CSR       = 7'b1110011;
    localparam logic [6:0] OPC_NOOP      = 7'b0000000;

    localparam logic [3:0] OP_ADD    = 4'd0;
    localparam logic [3:0] OP_SUB    = 4'd1;
    localparam logic [3:0] OP_SLL    = 4'd2;
    localparam logic [3:0] OP_SLT    = 4'd3;
    localparam logic [3:0] OP_SLTU   = 4'd4;
    localparam logic [3:0] OP_XOR    = 4'd5;
    localparam logic [3:0] OP_SRL    = 4'd6;
    localparam logic [3:0] OP_SRA    = 4'd7;
    localparam logic [3:0] OP_OR     = 4'd8;
    localparam logic [3:0] OP_AND    = 4'd9;
    localparam logic [3:0] OP_COPY_B = 4'd10;
    localparam logic [3:0] OP_COPY_A = 4'd11;
    localparam logic [3:0] OP_ZERO   = 4'd15;

    logic [3:0]  alu_op_s;
    logic [31:0] result_s;
    logic [4:0]  shamt_s;

    // Immediate forms never subtract: bit 30 is part of the immediate there.
    function automatic logic [3:0] decode_arith(input logic [2:0] f,
                                                input logic       alt,
                                                input logic       allow_sub);
        logic [3:0] op;
        case (f)
            3'b000: begin
                if (allow_sub && alt) begin
                    op = OP_SUB;
                end else begin
                    op = OP_ADD;
                end
            end
            3'b001: op = OP_SLL;
            3'b010: op = OP_SLT;
            3'b011: op = OP_SLTU;
            3'b100: op = OP_XOR;
            3'b101: begin
                if (alt) begin
                    op = OP_SRA;
                end else begin
                    op = OP_SRL;
                end
            end
            3'b110: op = OP_OR;
            3'b111: op = OP_AND;
            default: op = OP_ZERO;
        endcase
        return op;
    endfunction

    // Opcode to ALU operation decode.
    always_comb begin
        alu_op_s = OP_ZERO;
        case (opcode)
            OPC_LUI:       alu_op_s = OP_COPY_B;
            OPC_AUIPC,
            OPC_JAL,
            OPC_JALR,
            OPC_BRANCH,
            OPC_LOAD,
            OPC_STORE:     alu_op_s = OP_ADD;
            OPC_ARI_RTYPE: alu_op_s = decode_arith(funct, add_rshift_type, 1'b1);
            OPC_ARI_ITYPE: alu_op_s = decode_arith(funct, add_rshift_type, 1'b0);
            OPC_CSR:       alu_op_s = OP_COPY_A;
            OPC_NOOP:      alu_op_s = OP_ZERO;
            default:       alu_op_s = OP_ZERO;
        endcase
    end

    assign shamt_s = B[4:0];

    // Datapath result selected by the decoded operation.
    always_comb begin
        result_s = 32'd0;
        case (alu_op_s)
            OP_ADD:    result_s = A + B;
            OP_SUB:    result_s = A - B;
            OP_SLL:    result_s = A << shamt_s;
            OP_SLT:    result_s = ($signed(A) < $signed(B)) ? 32'd1 : 32'd0;
            OP_SLTU:   result_s = (A < B) ? 32'd1 : 32'd0;
            OP_XOR:    result_s = A ^ B;
            OP_SRL:    result_s = A >> shamt_s;
            OP_SRA:    result_s = $unsigned($signed(A) >>> shamt_s);
            OP_OR:     result_s = A | B;
            OP_AND:    result_s = A & B;
            OP_COPY_B: result_s = B;
            OP_COPY_A: result_s = A;
            default:   result_s = 32'd0;
        endcase
    end

    assign ALUop = alu_op_s;
    assign Out   = result_s;

`ifdef ALU_OUT_REG_EN
    logic [31:0] out_q_r;

    // Result register, cleared asynchronously by reset.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            out_q_r <= 32'd0;
        end else begin
            out_q_r <= result_s;
        end
    end

    assign Out_q = out_q_r;
`else
    logic unused_clk_rst_s;

    assign unused_clk_rst_s = ^{Clock, Reset_n};
    assign Out_q            = result_s;
`endif

endmodule

// File: tb/tb_alu_dec.sv
// Table-driven bench for alu_dec with an expected-result queue for Out_q.
module tb_alu_dec;

    logic        Clock;
    logic        Reset_n;
    logic [6:0]  opcode;
    logic [2:0]  funct;
    logic        add_rshift_type;
    logic [31:0] A;
    logic [31:0] B;
    logic [3:0]  ALUop;
    logic [31:0] Out;
    logic [31:0] Out_q;

    int n_total;
    int n_pass;

    typedef struct {
        logic [6:0]  op;
        logic [2:0]  f;
        logic        alt;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  exp_op;
        logic [31:0] exp_out;
    } vec_t;

    localparam int NV = 24;
    vec_t vecs [NV];
    logic [31:0] sb_q [$];

    alu_dec dut (
        .Clock           (Clock),
        .Reset_n         (Reset_n),
        .opcode          (opcode),
        .funct           (funct),
        .add_rshift_type (add_rshift_type),
        .A               (A),
        .B               (B),
        .ALUop           (ALUop),
        .Out             (Out),
        .Out_q           (Out_q)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        opcode          = v.op;
        funct           = v.f;
        add_rshift_type = v.alt;
        A               = v.a;
        B               = v.b;
    endtask

    initial begin
        vec_t        v;
        logic [31:0] exp_q;
        n_total = 0;
        n_pass  = 0;

        vecs[0]  = '{7'b0110011, 3'b000, 1'b1, 32'h00000005, 32'h00000007, 4'd1,  32'hFFFFFFFE};
        vecs[1]  = '{7'b0010011, 3'b101, 1'b1, 32'h80000000, 32'hFFFF8024, 4'd7,  32'hF8000000};
        vecs[2]  = '{7'b0010011, 3'b101, 1'b0, 32'h80000000, 32'hFFFF8024, 4'd6,  32'h08000000};
        vecs[3]  = '{7'b0110011, 3'b010, 1'b0, 32'hFFFFFFFF, 32'h00000001, 4'd3,  32'h00000001};
        vecs[4]  = '{7'b0110011, 3'b011, 1'b0, 32'hFFFFFFFF, 32'h00000001, 4'd4,  32'h00000000};
        vecs[5]  = '{7'b0110111, 3'b110, 1'b1, 32'hAAAA5555, 32'h12345000, 4'd10, 32'h12345000};
        vecs[6]  = '{7'b1110011, 3'b101, 1'b0, 32'hDEADBEEF, 32'h00000001, 4'd11, 32'hDEADBEEF};
        vecs[7]  = '{7'b0000000, 3'b011, 1'b1, 32'h12345678, 32'h9ABCDEF0, 4'd15, 32'h00000000};
        vecs[8]  = '{7'b0010011, 3'b000, 1'b1, 32'hFFFFFFFF, 32'h00000001, 4'd0,  32'h00000000};
        vecs[9]  = '{7'b0110011, 3'b000, 1'b0, 32'h7FFFFFFF, 32'h00000001, 4'd0,  32'h80000000};
        vecs[10] = '{7'b0110011, 3'b001, 1'b1, 32'h00000001, 32'h0000003F, 4'd2,  32'h80000000};
        vecs[11] = '{7'b0110011, 3'b100, 1'b0, 32'hF0F0F0F0, 32'hFF00FF00, 4'd5,  32'h0FF00FF0};
        vecs[12] = '{7'b0110011, 3'b110, 1'b1, 32'hF0F0F0F0, 32'hFF00FF00, 4'd8,  32'hFFF0FFF0};
        vecs[13] = '{7'b0110011, 3'b111, 1'b0, 32'hF0F0F0F0, 32'hFF00FF00, 4'd9,  32'hF000F000};
        vecs[14] = '{7'b1100111, 3'b000, 1'b0, 32'h00001000, 32'hFFFFFFFC, 4'd0,  32'h00000FFC};
        vecs[15] = '{7'b1100011, 3'b001, 1'b1, 32'h00000005, 32'h00000003, 4'd0,  32'h00000008};
        vecs[16] = '{7'b0100011, 3'b010, 1'b0, 32'h00000100, 32'h00000020, 4'd0,  32'h00000120};
        vecs[17] = '{7'b1111111, 3'b111, 1'b1, 32'h12345678, 32'h87654321, 4'd15, 32'h00000000};
        vecs[18] = '{7'b0110011, 3'b010, 1'b1, 32'h00000001, 32'hFFFFFFFF, 4'd3,  32'h00000000};
        vecs[19] = '{7'b0010011, 3'b011, 1'b1, 32'h00000001, 32'hFFFFFFFF, 4'd4,  32'h00000001};
        vecs[20] = '{7'b0110011, 3'b101, 1'b1, 32'h7FFFFFF0, 32'h00000020, 4'd7,  32'h7FFFFFF0};
        vecs[21] = '{7'b0010111, 3'b111, 1'b1, 32'hFFFFFFF0, 32'h00000020, 4'd0,  32'h00000010};
        vecs[22] = '{7'b1101111, 3'b100, 1'b0, 32'h00000008, 32'h00000004, 4'd0,  32'h0000000C};
        vecs[23] = '{7'b0110011, 3'b101, 1'b0, 32'h80000000, 32'h0000001F, 4'd6,  32'h00000001};

        // Reset phase: combinational path must keep working while Out_q is held at zero.
        Reset_n = 1'b0;
        drive(vecs[5]);
        repeat (2) @(posedge Clock);
        #1;
        check("rst_aluop", {28'd0, ALUop}, 32'd10);
        check("rst_out", Out, 32'h12345000);
`ifdef ALU_OUT_REG_EN
        check("rst_out_q", Out_q, 32'd0);
`else
        check("rst_out_q", Out_q, 32'h12345000);
`endif
        @(negedge Clock);
        Reset_n = 1'b1;
        drive(vecs[6]);
`ifdef ALU_OUT_REG_EN
        #1;
        check("rel_out_q_hold", Out_q, 32'd0);
        @(posedge Clock);
        #1;
        check("rel_first_load", Out_q, 32'hDEADBEEF);
`endif

        for (int i = 0; i < NV; i++) begin
            @(negedge Clock);
            v = vecs[i];
            drive(v);
            sb_q.push_back(v.exp_out);
            #1;
            check($sformatf("v%0d_aluop", i), {28'd0, ALUop}, {28'd0, v.exp_op});
            check($sformatf("v%0d_out", i), Out, v.exp_out);
`ifdef ALU_OUT_REG_EN
            @(posedge Clock);
            #1;
`endif
            exp_q = sb_q.pop_front();
            check($sformatf("v%0d_out_q", i), Out_q, exp_q);
        end

        // NOOP with an unknown funct must still decode to ZERO.
        @(negedge Clock);
        opcode          = 7'b0000000;
        funct           = 3'bxxx;
        add_rshift_type = 1'bx;
        A               = 32'hFFFFFFFF;
        B               = 32'hFFFFFFFF;
        #1;
        check("noop_x_aluop", {28'd0, ALUop}, 32'd15);
        check("noop_x_out", Out, 32'd0);

        // Mid-stream reset must clear Out_q without waiting for a clock edge.
        @(negedge Clock);
        drive(vecs[11]);
        @(posedge Clock);
        #1;
        check("pre_mid_rst_out_q", Out_q, 32'h0FF00FF0);
        @(negedge Clock);
        #2;
        Reset_n = 1'b0;
        #1;
`ifdef ALU_OUT_REG_EN
        check("mid_rst_out_q", Out_q, 32'd0);
`else
        check("mid_rst_out_q", Out_q, 32'h0FF00FF0);
`endif
        check("mid_rst_out", Out, 32'h0FF00FF0);
        @(negedge Clock);
        Reset_n = 1'b1;
        @(posedge Clock);
        #1;
        check("post_mid_rst_out_q", Out_q, 32'h0FF00FF0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
